// File: rtl/fir_tcdm_arbiter.sv
// Round-robin funnel of MP upstream TCDM ports onto one downstream master port.
// An in-order ID FIFO steers each downstream response back to its requester.
module fir_tcdm_arbiter #(
  parameter int unsigned MP         = 4,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [MP-1:0]              in_req,
  output logic [MP-1:0]              in_gnt,
  input  logic [MP-1:0][AW-1:0]      in_add,
  input  logic [MP-1:0]              in_wen,
  input  logic [MP-1:0][DW/8-1:0]    in_be,
  input  logic [MP-1:0][DW-1:0]      in_data,
  output logic [MP-1:0][DW-1:0]      in_r_data,
  output logic [MP-1:0]              in_r_valid,
  output logic                       out_req,
  input  logic                       out_gnt,
  output logic [AW-1:0]              out_add,
  output logic                       out_wen,
  output logic [DW/8-1:0]            out_be,
  output logic [DW-1:0]              out_data,
  input  logic [DW-1:0]              out_r_data,
  input  logic                       out_r_valid,
  output logic                       err_o
);

  localparam int unsigned IW = $clog2(MP);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_fifo [RESP_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // First requesting port at or after rr_ptr, wrapping modulo MP
  always_comb begin
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < MP; k++) begin
      w_idx = IW'((32'(r_rr_ptr) + k) % MP);
      if (!w_found && in_req[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // Full comes from registered count, so a pop while full frees a slot next cycle
  assign w_full   = (r_count == CW'(RESP_DEPTH));
  assign out_req  = (|in_req) & ~w_full;
  assign w_push   = out_req & out_gnt;
  assign w_pop    = out_r_valid & (r_count != '0);

  assign out_add  = out_req ? in_add[w_sel]  : '0;
  assign out_wen  = out_req ? in_wen[w_sel]  : 1'b0;
  assign out_be   = out_req ? in_be[w_sel]   : '0;
  assign out_data = out_req ? in_data[w_sel] : '0;

  assign in_r_data = {MP{out_r_data}};
  assign err_o     = r_err;

  always_comb begin
    in_gnt     = '0;
    in_r_valid = '0;
    if (w_push) in_gnt[w_sel] = 1'b1;
    if (w_pop)  in_r_valid[r_fifo[r_rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
        r_rr_ptr         <= (w_sel == IW'(MP - 1)) ? '0 : w_sel + IW'(1);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      // Response with nothing outstanding is a downstream protocol violation
      if (out_r_valid && (r_count == '0)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_tcdm_arbiter.sv
// Directed and randomized checks of fir_tcdm_arbiter against a queue-based model.
module tb_fir_tcdm_arbiter;

  localparam int MP    = 4;
  localparam int DEPTH = 4;

  logic              clk_i;
  logic              rst_ni;
  logic [3:0]        in_req;
  logic [3:0]        in_gnt;
  logic [3:0][31:0]  in_add;
  logic [3:0]        in_wen;
  logic [3:0][3:0]   in_be;
  logic [3:0][31:0]  in_data;
  logic [3:0][31:0]  in_r_data;
  logic [3:0]        in_r_valid;
  logic              out_req;
  logic              out_gnt;
  logic [31:0]       out_add;
  logic              out_wen;
  logic [3:0]        out_be;
  logic [31:0]       out_data;
  logic [31:0]       out_r_data;
  logic              out_r_valid;
  logic              err_o;

  int n_vec;
  int n_err;

  // Reference model: outstanding requester IDs in order, rotating priority, sticky error
  int m_q[$];
  int m_rr;
  bit m_err;

  fir_tcdm_arbiter #(.MP(MP), .RESP_DEPTH(DEPTH), .AW(32), .DW(32)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
    .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then advance one clock and update the model
  task automatic cycle();
    int sel;
    bit ereq;
    bit hs;
    logic [3:0]  eg;
    logic [3:0]  erv;
    logic [31:0] eadd;
    logic [31:0] edata;
    logic [3:0]  ebe;
    logic        ewen;
    #2;
    sel = -1;
    for (int k = 0; k < MP; k++) begin
      int p;
      p = (m_rr + k) % MP;
      if (sel < 0 && in_req[p]) sel = p;
    end
    ereq  = (sel >= 0) && (m_q.size() < DEPTH);
    hs    = ereq && out_gnt;
    eg    = '0;
    erv   = '0;
    eadd  = '0;
    edata = '0;
    ebe   = '0;
    ewen  = 1'b0;
    if (ereq) begin
      eadd  = in_add[sel];
      edata = in_data[sel];
      ebe   = in_be[sel];
      ewen  = in_wen[sel];
    end
    if (hs) eg = 4'(1 << sel);
    if (out_r_valid && m_q.size() > 0) erv = 4'(1 << m_q[0]);
    chk("out_req", 64'(out_req), 64'(ereq));
    chk("out_add", 64'(out_add), 64'(eadd));
    chk("out_wen", 64'(out_wen), 64'(ewen));
    chk("out_be", 64'(out_be), 64'(ebe));
    chk("out_data", 64'(out_data), 64'(edata));
    chk("in_gnt", 64'(in_gnt), 64'(eg));
    chk("in_r_valid", 64'(in_r_valid), 64'(erv));
    chk("err_o", 64'(err_o), 64'(m_err));
    if (erv != '0) chk("in_r_data", 64'(in_r_data[m_q[0]]), 64'(out_r_data));
    if (out_r_valid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (hs) begin
      m_q.push_back(sel);
      m_rr = (sel + 1) % MP;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_req      = '0;
    out_gnt     = 1'b0;
    out_r_valid = 1'b0;
    out_r_data  = '0;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    model_clear();
    cycle();
    rst_ni = 1'b1;
  endtask

  task automatic rand_fields();
    for (int p = 0; p < MP; p++) begin
      in_add[p]  = $urandom;
      in_data[p] = $urandom;
      in_be[p]   = 4'($urandom);
      in_wen[p]  = 1'($urandom);
    end
  endtask

  initial begin
    int p;
    logic [31:0] a0;
    logic [31:0] a1;
    n_vec   = 0;
    n_err   = 0;
    in_add  = '0;
    in_data = '0;
    in_be   = '0;
    in_wen  = '0;
    do_reset();

    // Single read from port 2, response next cycle
    do_reset();
    in_req = 4'b0100; in_add[2] = 32'h100; in_wen[2] = 1'b1; out_gnt = 1'b1;
    #1;
    chk("t1_out_req", 64'(out_req), 64'd1);
    chk("t1_out_add", 64'(out_add), 64'h100);
    chk("t1_in_gnt", 64'(in_gnt), 64'b0100);
    cycle();
    in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1; out_r_data = 32'hDEADBEEF;
    #1;
    chk("t1_in_r_valid", 64'(in_r_valid), 64'b0100);
    chk("t1_in_r_data2", 64'(in_r_data[2]), 64'hDEADBEEF);
    cycle();
    idle();

    // All ports requesting: rotation 0,1,2,3,0,1 with responses one cycle behind
    do_reset();
    rand_fields();
    in_req = 4'b1111; out_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      out_r_valid = (k > 0);
      out_r_data  = $urandom;
      #1;
      chk("t2_in_gnt", 64'(in_gnt), 64'(1 << (k % 4)));
      if (k > 0) chk("t2_in_r_valid", 64'(in_r_valid), 64'(1 << ((k - 1) % 4)));
      cycle();
    end
    in_req = '0; out_r_valid = 1'b1; out_r_data = $urandom;
    #1;
    chk("t2_in_r_valid_last", 64'(in_r_valid), 64'b0010);
    cycle();
    idle();

    // Stall with out_gnt low: port 1 presented and held, then granted before port 2
    do_reset();
    rand_fields();
    a1 = in_add[1];
    in_req = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_out_add_held", 64'(out_add), 64'(a1));
      chk("t4_in_gnt_stall", 64'(in_gnt), 64'd0);
      cycle();
    end
    out_gnt = 1'b1;
    #1;
    chk("t4_first_gnt", 64'(in_gnt), 64'b0010);
    cycle();
    #1;
    chk("t4_second_gnt", 64'(in_gnt), 64'b0100);
    cycle();
    in_req = '0; out_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out_r_valid = 1'b1; out_r_data = $urandom;
      cycle();
    end
    idle();

    // Fill the ID FIFO, then one response frees a slot from the next cycle
    do_reset();
    rand_fields();
    in_req = 4'b0001; out_gnt = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk("t3_fill_gnt", 64'(in_gnt), 64'b0001);
      cycle();
    end
    #1;
    chk("t3_full_out_req", 64'(out_req), 64'd0);
    chk("t3_full_in_gnt", 64'(in_gnt), 64'd0);
    cycle();
    out_r_valid = 1'b1; out_r_data = $urandom;
    #1;
    chk("t3_pop_rvalid", 64'(in_r_valid), 64'b0001);
    chk("t3_pop_out_req", 64'(out_req), 64'd0);
    cycle();
    out_r_valid = 1'b0;
    #1;
    chk("t3_reassert", 64'(out_req), 64'd1);
    chk("t3_next_gnt", 64'(in_gnt), 64'b0001);
    cycle();
    in_req = '0; out_gnt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      out_r_valid = 1'b1; out_r_data = $urandom;
      cycle();
    end
    idle();

    // Random traffic with a well-behaved downstream
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rand_fields();
      in_req      = 4'($urandom);
      out_gnt     = ($urandom_range(0, 3) != 0);
      out_r_valid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      out_r_data  = $urandom;
      cycle();
    end
    in_req = '0; out_gnt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      out_r_valid = (m_q.size() > 0); out_r_data = $urandom;
      cycle();
    end
    idle();

    // Spurious response while idle sets a sticky error
    do_reset();
    out_r_valid = 1'b1; out_r_data = $urandom;
    #1;
    chk("t5_no_rvalid", 64'(in_r_valid), 64'd0);
    cycle();
    out_r_valid = 1'b0;
    #1;
    chk("t5_err_set", 64'(err_o), 64'd1);
    cycle();
    for (int k = 0; k < 10; k++) begin
      rand_fields();
      p = $urandom_range(0, 3);
      in_req = 4'(1 << p); out_gnt = 1'b1;
      cycle();
      in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1; out_r_data = $urandom;
      #1;
      chk("t5_clean_rvalid", 64'(in_r_valid), 64'(1 << p));
      cycle();
      out_r_valid = 1'b0;
    end
    #1;
    chk("t5_err_sticky", 64'(err_o), 64'd1);
    cycle();

    // Reset with reads outstanding discards them; a late response flags an error
    do_reset();
    rand_fields();
    in_req = 4'b0001; in_wen[0] = 1'b1; out_gnt = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    idle();
    rst_ni = 1'b0;
    model_clear();
    #1;
    chk("t6_rst_err", 64'(err_o), 64'd0);
    chk("t6_rst_out_req", 64'(out_req), 64'd0);
    cycle();
    rst_ni = 1'b1;
    rand_fields();
    a0 = in_add[0];
    in_req = 4'b1111;
    #1;
    chk("t6_rr_zero", 64'(out_add), 64'(a0));
    cycle();
    in_req = '0; out_r_valid = 1'b1; out_r_data = $urandom;
    #1;
    chk("t6_late_no_rvalid", 64'(in_r_valid), 64'd0);
    cycle();
    out_r_valid = 1'b0;
    #1;
    chk("t6_late_err", 64'(err_o), 64'd1);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
